// File: rtl/rs232_baud_timer.sv
`default_nettype none
// ============================================================================
// Module   : rs232_baud_timer
// Purpose  : Run-time programmable RS-232 bit-period timer. A run consists of
//            N bit periods of D clock cycles each; the first period may be
//            shortened to H = D>>1 cycles so that a receiver samples at the
//            centre of each bit. A one-cycle tick marks the end of every
//            period and a one-cycle done pulse accompanies the final tick.
// Ports    : clk_i         system clock, rising edge
//            reset_n_i     synchronous active-low reset
//            start_i       request (or retrigger) a run
//            abort_i       cancel the current run (beats start_i)
//            divisor_i     D, cycles per full bit period (latched at start)
//            n_bits_i      N, periods per run (latched at start)
//            half_first_i  first period is H cycles (latched at start)
//            tick_o        one-cycle pulse at the end of every period
//            done_o        one-cycle pulse at the end of the final period
//            busy_o        high whenever the state is not IDLE
//            state_o       IDLE=0, HALF=1, RUN=2, DONE=3
// Revision : 1.0 - initial release
// ============================================================================
module rs232_baud_timer #(
   parameter int DIV_WIDTH = 16,
   parameter int CNT_WIDTH = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [DIV_WIDTH-1:0] divisor_i,
   input  logic [CNT_WIDTH-1:0] n_bits_i,
   input  logic                 half_first_i,
   output logic                 tick_o,
   output logic                 done_o,
   output logic                 busy_o,
   output logic [1:0]           state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HALF = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [DIV_WIDTH-1:0] c_div_one  = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] c_div_two  = DIV_WIDTH'(2);
   localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;
   localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;    // cycles left in current period
   logic [DIV_WIDTH-1:0] div_q,   div_d;    // latched (clamped) divisor
   logic [CNT_WIDTH-1:0] rem_q,   rem_d;    // periods left, including current
   logic                 tick_q,  tick_d;
   logic                 done_q,  done_d;

   logic [DIV_WIDTH-1:0] w_div_clamped;
   logic [DIV_WIDTH-1:0] w_half;
   logic [DIV_WIDTH-1:0] w_first_load;
   logic [CNT_WIDTH-1:0] w_nbits_clamped;
   logic                 w_expire;
   logic                 w_final;

   // Clamping D to at least 2 guarantees H >= 1, so the first-period load
   // value H-1 can never underflow.
   assign w_div_clamped   = (divisor_i < c_div_two) ? c_div_two : divisor_i;
   assign w_half          = w_div_clamped >> 1;
   assign w_first_load    = half_first_i ? (w_half - c_div_one)
                                         : (w_div_clamped - c_div_one);
   assign w_nbits_clamped = (n_bits_i == c_cnt_zero) ? c_cnt_one : n_bits_i;

   // A period expires on the edge at which the counter is already zero; the
   // reload happens on that same edge so the counter never wraps.
   assign w_expire = (cnt_q == '0);
   assign w_final  = (rem_q <= c_cnt_one);

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      rem_d   = rem_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;

      if (abort_i) begin
         // Abort wins over start and over a coincident expiry.
         state_d = S_IDLE;
      end else if (start_i) begin
         // Accepted in every state; in HALF/RUN the abandoned period emits
         // nothing.
         state_d = half_first_i ? S_HALF : S_RUN;
         cnt_d   = w_first_load;
         div_d   = w_div_clamped;
         rem_d   = w_nbits_clamped;
      end else begin
         case (state_q)
            S_HALF, S_RUN: begin
               if (!w_expire) begin
                  cnt_d = cnt_q - c_div_one;
               end else if (w_final) begin
                  tick_d  = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  tick_d  = 1'b1;
                  cnt_d   = div_q - c_div_one;
                  rem_d   = rem_q - c_cnt_one;
                  state_d = S_RUN;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

   assign tick_o  = tick_q;
   assign done_o  = done_q;
   assign busy_o  = (state_q != S_IDLE);
   assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rs232_baud_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs232_baud_timer
// Purpose  : Self-checking bench for rs232_baud_timer. Every clock edge is
//            compared against an arithmetic reference model (tick positions
//            derived from run start, D, H and N); run-level vectors and
//            hand-written sequences check tick/done edge lists.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs232_baud_timer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [15:0] divisor;
   logic [3:0]  n_bits;
   logic        half_first;
   logic        tick;
   logic        done;
   logic        busy;
   logic [1:0]  state;

   rs232_baud_timer #(
      .DIV_WIDTH (16),
      .CNT_WIDTH (4)
   ) dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .start_i      (start),
      .abort_i      (abort),
      .divisor_i    (divisor),
      .n_bits_i     (n_bits),
      .half_first_i (half_first),
      .tick_o       (tick),
      .done_o       (done),
      .busy_o       (busy),
      .state_o      (state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int e        = 0;   // absolute edge count
   int rel      = 0;   // edge index relative to current sequence start
   int tick_log[$];
   int done_log[$];

   // Reference model: run described by start edge, D, H, N and mode.
   int         m_mode = 0;   // 0 idle, 1 running, 2 done
   int         m_s, m_D, m_N, m_H;
   logic       m_hf;
   logic       m_tick, m_done;
   logic [1:0] m_state;

   task automatic model_edge(input logic rn, input logic st, input logic ab,
                             input logic [15:0] d, input logic [3:0] n,
                             input logic hf);
      int t;
      int first;
      m_tick = 1'b0;
      m_done = 1'b0;
      if (!rn || ab) begin
         m_mode = 0;
      end else if (st) begin
         m_mode = 1;
         m_s    = e;
         m_D    = (int'(d) < 2) ? 2 : int'(d);
         m_N    = (n == 4'd0) ? 1 : int'(n);
         m_H    = m_D / 2;
         m_hf   = hf;
      end else if (m_mode == 1) begin
         t     = e - m_s;
         first = m_hf ? m_H : m_D;
         if (t >= first && ((t - first) % m_D) == 0) begin
            m_tick = 1'b1;
            if ((t - first) / m_D + 1 == m_N) begin
               m_done = 1'b1;
               m_mode = 2;
            end
         end
      end else if (m_mode == 2) begin
         m_mode = 0;
      end
      case (m_mode)
         0:       m_state = 2'd0;
         2:       m_state = 2'd3;
         default: m_state = (m_hf && (e - m_s) < m_H) ? 2'd1 : 2'd2;
      endcase
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic check_q(input string name, input int expq[$]);
      string a;
      string x;
      a = "";
      x = "";
      foreach (tick_log[i]) a = {a, $sformatf("%0d ", tick_log[i])};
      foreach (expq[i])     x = {x, $sformatf("%0d ", expq[i])};
      checks++;
      if (a != x) begin
         failures++;
         $display("FAIL %s actual=[%s] expected=[%s]", name, a, x);
      end
   endtask

   task automatic check_dq(input string name, input int expq[$]);
      string a;
      string x;
      a = "";
      x = "";
      foreach (done_log[i]) a = {a, $sformatf("%0d ", done_log[i])};
      foreach (expq[i])     x = {x, $sformatf("%0d ", expq[i])};
      checks++;
      if (a != x) begin
         failures++;
         $display("FAIL %s actual=[%s] expected=[%s]", name, a, x);
      end
   endtask

   task automatic step(input logic rn, input logic st, input logic ab,
                       input logic [15:0] d, input logic [3:0] n,
                       input logic hf);
      reset_n    = rn;
      start      = st;
      abort      = ab;
      divisor    = d;
      n_bits     = n;
      half_first = hf;
      @(posedge clk);
      e++;
      model_edge(rn, st, ab, d, n, hf);
      #1;
      check_int($sformatf("outputs_edge%0d", e),
                int'({state, busy, done, tick}),
                int'({m_state, (m_state != 2'd0), m_done, m_tick}));
      if (tick) tick_log.push_back(rel);
      if (done) done_log.push_back(rel);
      rel++;
   endtask

   // Idle cycles with random values on the latched inputs.
   task automatic idle(input int k);
      for (int i = 0; i < k; i++)
         step(1'b1, 1'b0, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
   endtask

   task automatic begin_seq();
      tick_log.delete();
      done_log.delete();
      rel = 0;
   endtask

   typedef struct {
      logic [15:0] d;
      logic [3:0]  n;
      logic        hf;
      logic [1:0]  st0;     // state right after the start edge
      int          first;   // edge of first tick
      int          last;    // edge of done
      int          count;   // ticks in the run
   } vec_t;

   vec_t vecs[7];
   int   expq[$];

   initial begin
      vecs[0] = '{16'd5,  4'd3,  1'b0, 2'd2, 5, 15, 3};
      vecs[1] = '{16'd10, 4'd3,  1'b1, 2'd1, 5, 25, 3};
      vecs[2] = '{16'd0,  4'd0,  1'b0, 2'd2, 2, 2,  1};
      vecs[3] = '{16'd1,  4'd2,  1'b1, 2'd1, 1, 3,  2};
      vecs[4] = '{16'd7,  4'd0,  1'b1, 2'd1, 3, 3,  1};
      vecs[5] = '{16'd3,  4'd15, 1'b0, 2'd2, 3, 45, 15};
      vecs[6] = '{16'd2,  4'd1,  1'b1, 2'd1, 1, 1,  1};

      // Reset
      step(1'b0, 1'b1, 1'b0, 16'd5, 4'd3, 1'b0);
      step(1'b0, 1'b0, 1'b0, 16'd5, 4'd3, 1'b0);
      check_int("reset_state", int'({state, busy, done, tick}), 0);

      // Run-level vectors
      foreach (vecs[v]) begin
         begin_seq();
         step(1'b1, 1'b1, 1'b0, vecs[v].d, vecs[v].n, vecs[v].hf);
         check_int($sformatf("vec%0d_state0", v), int'(state), int'(vecs[v].st0));
         for (int c = 0; c < 100 && done_log.size() == 0; c++) idle(1);
         check_int($sformatf("vec%0d_first_tick", v),
                   (tick_log.size() > 0) ? tick_log[0] : -1, vecs[v].first);
         check_int($sformatf("vec%0d_done_edge", v),
                   (done_log.size() > 0) ? done_log[0] : -1, vecs[v].last);
         check_int($sformatf("vec%0d_tick_count", v), tick_log.size(), vecs[v].count);
         idle(1);
         check_int($sformatf("vec%0d_idle_after", v), int'(state), 0);
      end

      // Retrigger at edge 12
      begin_seq();
      step(1'b1, 1'b1, 1'b0, 16'd8, 4'd4, 1'b0);
      idle(11);
      step(1'b1, 1'b1, 1'b0, 16'd4, 4'd1, 1'b0);
      idle(5);
      expq = {8, 16};
      check_q("retrigger_ticks", expq);
      expq = {16};
      check_dq("retrigger_done", expq);

      // Abort at edge 20
      begin_seq();
      step(1'b1, 1'b1, 1'b0, 16'd8, 4'd4, 1'b0);
      idle(19);
      step(1'b1, 1'b0, 1'b1, 16'd8, 4'd4, 1'b0);
      check_int("abort_state", int'(state), 0);
      idle(10);
      expq = {8, 16};
      check_q("abort_ticks", expq);
      expq = {};
      check_dq("abort_done", expq);

      // Abort coinciding with the final expiry
      begin_seq();
      step(1'b1, 1'b1, 1'b0, 16'd2, 4'd1, 1'b0);
      idle(1);
      step(1'b1, 1'b0, 1'b1, 16'd2, 4'd1, 1'b0);
      idle(2);
      expq = {};
      check_q("abort_final_ticks", expq);
      check_dq("abort_final_done", expq);

      // Back-to-back runs: start sampled during the DONE cycle
      begin_seq();
      step(1'b1, 1'b1, 1'b0, 16'd3, 4'd2, 1'b0);
      idle(6);
      check_int("b2b_done_state", int'(state), 3);
      step(1'b1, 1'b1, 1'b0, 16'd3, 4'd2, 1'b0);
      check_int("b2b_restart_state", int'(state), 2);
      idle(7);
      expq = {3, 6, 10, 13};
      check_q("b2b_ticks", expq);
      expq = {6, 13};
      check_dq("b2b_done", expq);

      // Reset mid-run at edge 7 (start also high: reset wins)
      begin_seq();
      step(1'b1, 1'b1, 1'b0, 16'd5, 4'd3, 1'b0);
      idle(6);
      step(1'b0, 1'b1, 1'b0, 16'd5, 4'd3, 1'b0);
      check_int("midrun_reset_outputs", int'({state, busy, done, tick}), 0);
      idle(9);
      expq = {5};
      check_q("midrun_reset_ticks", expq);
      expq = {};
      check_dq("midrun_reset_done", expq);

      // Abort and start together in IDLE
      step(1'b1, 1'b1, 1'b1, 16'd5, 4'd3, 1'b0);
      check_int("abort_start_idle", int'(state), 0);
      idle(1);
      check_int("abort_start_idle_next", int'(state), 0);

      // Randomised traffic against the reference model
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 99) < 4),
              ($urandom_range(0, 99) < 2),
              16'($urandom_range(0, 12)),
              4'($urandom_range(0, 5)),
              1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
